// File: rtl/keypad_pkg.sv
// Shared types and constants for the matrix-keypad scanner.
// Key codes 0-9 are digits, 10-15 are calculator operators.
package keypad_pkg;

    localparam int CODE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAND,
        ST_PRESSED
    } key_state_e;

    // Indexed by idx = col*4 + row on the 4x4 calculator pad.
    localparam logic [CODE_W-1:0] KEY_MAP_4X4 [16] = '{
        8'h01, 8'h04, 8'h07, 8'h0E,
        8'h02, 8'h05, 8'h08, 8'h00,
        8'h03, 8'h06, 8'h09, 8'h0F,
        8'h0A, 8'h0B, 8'h0C, 8'h0D
    };

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchroniser for the asynchronous, active-low keypad row inputs.
module keypad_row_sync #(
    parameter int ROWS = 4
) (
    input  logic            clk,
    input  logic            key_clr,
    input  logic [ROWS-1:0] rows_i,
    output logic [ROWS-1:0] rows_o
);

    logic [ROWS-1:0] meta_q;
    logic [ROWS-1:0] sync_q;

    // Idle rows read high, so reset to all ones to avoid a phantom key.
    always_ff @(posedge clk or negedge key_clr) begin
        if (!key_clr) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= rows_i;
            sync_q <= meta_q;
        end
    end

    assign rows_o = sync_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Keypad scanner: column strobing, per-frame key evaluation, frame-based
// debounce with optional auto-repeat, and a nibble shift buffer.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int ROWS          = 4,
    parameter int COLS          = 4,
    parameter int SCAN_DIV      = 1000,
    parameter int DEBOUNCE      = 4,
    parameter int DIGITS        = 2,
    parameter int USE_MAP       = 1,
    parameter int REPEAT_EN     = 0,
    parameter int REPEAT_FRAMES = 32
) (
    input  logic                         clk,
    input  logic                         key_clr,
    input  logic [ROWS-1:0]              KEY_R,
    output logic [COLS-1:0]              KEY_C,
    input  logic                         buf_clr,
    output logic [CODE_W-1:0]            key_code,
    output logic                         key_valid,
    output logic                         multi_key,
    output logic [4*DIGITS-1:0]          out,
    output logic [$clog2(DIGITS+1)-1:0]  digit_cnt
);

    localparam int ROW_W = $clog2(ROWS);
    localparam int COL_W = $clog2(COLS);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int IDX_W = $clog2(ROWS * COLS);
    localparam int CNT_W = $clog2(DIGITS + 1);
    localparam int DBC_W = 4;
    localparam int RPT_W = $clog2(REPEAT_FRAMES + 1);
    localparam int OUT_W = 4 * DIGITS;

    logic [ROWS-1:0] rows_sync;

    keypad_row_sync #(.ROWS(ROWS)) u_row_sync (
        .clk     (clk),
        .key_clr (key_clr),
        .rows_i  (KEY_R),
        .rows_o  (rows_sync)
    );

    logic [DIV_W-1:0] div_q;
    logic [COL_W-1:0] col_q;
    logic             last_dwell, frame_end;

    assign last_dwell = (div_q == DIV_W'(SCAN_DIV - 1));
    assign frame_end  = last_dwell && (col_q == COL_W'(COLS - 1));
    assign KEY_C      = ~(COLS'(1) << col_q);

    // Lowest active row in the strobed column; a second active row flags multi.
    logic             col_hit, col_multi;
    logic [ROW_W-1:0] col_row;
    logic [IDX_W-1:0] col_idx;

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        col_hit   = 1'b0;
        col_multi = 1'b0;
        col_row   = '0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (!rows_sync[r]) begin
                if (col_hit) col_multi = 1'b1;
                col_hit = 1'b1;
                col_row = ROW_W'(r);
            end
        end
    end

    assign col_idx = IDX_W'(col_q) * IDX_W'(ROWS) + IDX_W'(col_row);

    logic             acc_hit_q, acc_multi_q;
    logic [IDX_W-1:0] acc_idx_q;
    logic             frm_hit, frm_multi;
    logic [IDX_W-1:0] frm_idx;

    // Columns are visited in ascending order, so the first hit of a frame is its lowest idx.
    assign frm_hit   = acc_hit_q | col_hit;
    assign frm_idx   = acc_hit_q ? acc_idx_q : col_idx;
    assign frm_multi = acc_multi_q | col_multi | (acc_hit_q & col_hit);

    key_state_e       state_q, state_d;
    logic [IDX_W-1:0] cand_q, cand_d;
    logic [DBC_W-1:0] cnt_q, cnt_d, rel_q, rel_d;
    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic             accept;
    logic             same_key;

    assign same_key = frm_hit && (frm_idx == cand_q);

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge key_clr) begin
        if (!key_clr) begin
            state_q <= ST_IDLE;
            cand_q  <= '0;
            cnt_q   <= '0;
            rel_q   <= '0;
            rpt_q   <= '0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            rel_q   <= rel_d;
            rpt_q   <= rpt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        rel_d   = rel_q;
        rpt_d   = rpt_q;
        if (frame_end) begin
            unique case (state_q)
                ST_IDLE: if (frm_hit) begin
                    cand_d  = frm_idx;
                    cnt_d   = DBC_W'(1);
                    rel_d   = '0;
                    rpt_d   = '0;
                    state_d = accept ? ST_PRESSED : ST_CAND;
                end
                ST_CAND: begin
                    if (!frm_hit) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (same_key) begin
                        cnt_d = cnt_q + DBC_W'(1);
                        if (accept) begin
                            state_d = ST_PRESSED;
                            rel_d   = '0;
                            rpt_d   = '0;
                        end
                    end else begin
                        cand_d = frm_idx;
                        cnt_d  = DBC_W'(1);
                    end
                end
                ST_PRESSED: begin
                    if (frm_hit) begin
                        rel_d = '0;
                        if (same_key) rpt_d = accept ? '0 : rpt_q + RPT_W'(1);
                    end else if (rel_q + DBC_W'(1) == DBC_W'(DEBOUNCE)) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        rel_d   = '0;
                        rpt_d   = '0;
                    end else begin
                        rel_d = rel_q + DBC_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        accept = 1'b0;
        if (frame_end && frm_hit) begin
            unique case (state_q)
                ST_IDLE:    accept = (DEBOUNCE == 1);
                ST_CAND:    accept = same_key && (cnt_q + DBC_W'(1) == DBC_W'(DEBOUNCE));
                ST_PRESSED: accept = (REPEAT_EN != 0) && same_key &&
                                     (rpt_q + RPT_W'(1) == RPT_W'(REPEAT_FRAMES));
                default:    accept = 1'b0;
            endcase
        end
    end

    logic [CODE_W-1:0] code;
    logic [3:0]        map_idx;

    assign map_idx = 4'(frm_idx);
    assign code    = (USE_MAP != 0) ? KEY_MAP_4X4[map_idx] : CODE_W'(frm_idx);

    logic [CODE_W-1:0] code_q;
    logic              valid_q, multi_q;
    logic [OUT_W-1:0]  out_q;
    logic [CNT_W-1:0]  dcnt_q;

    always_ff @(posedge clk or negedge key_clr) begin
        if (!key_clr) begin
            div_q       <= '0;
            col_q       <= '0;
            acc_hit_q   <= 1'b0;
            acc_multi_q <= 1'b0;
            acc_idx_q   <= '0;
            code_q      <= '0;
            valid_q     <= 1'b0;
            multi_q     <= 1'b0;
            out_q       <= '0;
            dcnt_q      <= '0;
        end else begin
            valid_q <= accept;
            if (last_dwell) begin
                div_q <= '0;
                if (frame_end) begin
                    col_q       <= '0;
                    acc_hit_q   <= 1'b0;
                    acc_multi_q <= 1'b0;
                    acc_idx_q   <= '0;
                    multi_q     <= frm_multi;
                end else begin
                    col_q       <= col_q + COL_W'(1);
                    acc_hit_q   <= frm_hit;
                    acc_multi_q <= frm_multi;
                    acc_idx_q   <= frm_idx;
                end
            end else begin
                div_q <= div_q + DIV_W'(1);
            end
            if (accept) code_q <= code;
            if (buf_clr) begin
                out_q  <= '0;
                dcnt_q <= '0;
            end else if (accept) begin
                out_q <= (out_q << 4) | OUT_W'(code[3:0]);
                if (dcnt_q != CNT_W'(DIGITS)) dcnt_q <= dcnt_q + CNT_W'(1);
            end
        end
    end

    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign multi_key = multi_q;
    assign out       = out_q;
    assign digit_cnt = dcnt_q;

endmodule
